// File: rtl/inst_encode_writer.sv
// inst_encode_writer
// Packs RV32I instruction fields plus a full 32-bit immediate into an
// instruction word, buffers legal words in a small FIFO and streams them to an
// instruction-memory write port at consecutive word addresses. Bundles whose
// immediate cannot be represented are still accepted but dropped, and raise
// the sticky err_imm flag.
// Optional build macro: INST_ENC_SHAMT_CHECK_EN enables strict shift-amount
// checking for SLLI/SRLI/SRAI (opcode 0010011, funct3 001/101).
module inst_encode_writer #(
    parameter int                    FIFO_DEPTH = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [6:0]                    in_opcode,
    input  logic [4:0]                    in_rd,
    input  logic [4:0]                    in_rs1,
    input  logic [4:0]                    in_rs2,
    input  logic [2:0]                    in_funct3,
    input  logic [6:0]                    in_funct7,
    input  logic [31:0]                   in_imm,
    input  logic                          err_clear,
    output logic                          mem_wr_en,
    input  logic                          mem_ready,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [31:0]                   mem_wr_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_imm,
    output logic [15:0]                   words_written
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic {
        W_IDLE  = 1'b0,
        W_WRITE = 1'b1
    } wstate_t;

    wstate_t                 state_q, state_d;
    logic [31:0]             fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    err_q;
    logic [15:0]             words_q;

    logic [31:0]             encWord;
    logic                    encLegal;
    logic                    immFits12, immFits13, immFits21;
    logic                    accept, push, pop;

    // Sign-extension checks: the immediate fits when all upper bits match the sign bit
    assign immFits12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign immFits13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign immFits21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    // Combinational encoder: select the format from the opcode, place the fields and judge legality
    always_comb begin
        encWord  = '0;
        encLegal = 1'b0;
        case (in_opcode)
            OP_IMM, OP_LOAD, OP_JALR: begin
                encWord  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                encLegal = immFits12;
`ifdef INST_ENC_SHAMT_CHECK_EN
                if (in_opcode == OP_IMM && (in_funct3 == 3'b001 || in_funct3 == 3'b101)) begin
                    encLegal = (in_imm[31:12] == 20'd0) &&
                               ((in_imm[11:5] == 7'b0000000) ||
                                (in_funct3 == 3'b101 && in_imm[11:5] == 7'b0100000));
                end
`endif
            end
            OP_STORE: begin
                encWord  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                encLegal = immFits12;
            end
            OP_BRANCH: begin
                encWord  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
                encLegal = immFits13 && !in_imm[0];
            end
            OP_LUI, OP_AUIPC: begin
                encWord  = {in_imm[31:12], in_rd, in_opcode};
                encLegal = (in_imm[11:0] == 12'd0);
            end
            OP_JAL: begin
                encWord  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                encLegal = immFits21 && !in_imm[0];
            end
            OP_REG: begin
                encWord  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                encLegal = 1'b1;
            end
            default: begin
                encWord  = '0;
                encLegal = 1'b0;
            end
        endcase
    end

    assign in_ready = (count_q < CNT_W'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;
    assign push     = accept && encLegal;
    assign pop      = (state_q == W_WRITE) && mem_ready;

    // Occupancy next-state: simultaneous push and pop leave the count unchanged
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Writer FSM next-state and write-port outputs; a push this edge makes the word visible next cycle
    always_comb begin
        state_d     = state_q;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state_q)
            W_IDLE: begin
                if (count_d != '0) state_d = W_WRITE;
            end
            W_WRITE: begin
                mem_wr_en   = 1'b1;
                mem_wr_data = fifoMem_q[rdPtr_q];
                if (count_d == '0) state_d = W_IDLE;
            end
            default: state_d = W_IDLE;
        endcase
    end

    // FIFO storage; pointers are reset separately so the data array needs no reset
    always_ff @(posedge clk) begin
        if (push) fifoMem_q[wrPtr_q] <= encWord;
    end

    // Control state, pointers, address, counters and sticky error flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= W_IDLE;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            addr_q  <= BASE_ADDR;
            err_q   <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
                addr_q  <= addr_q + ADDR_WIDTH'(4);
                words_q <= words_q + 16'd1;
            end
            if (accept && !encLegal) err_q <= 1'b1;
            else if (err_clear)      err_q <= 1'b0;
        end
    end

    assign mem_addr      = addr_q;
    assign fifo_count    = count_q;
    assign err_imm       = err_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_inst_encode_writer.sv
// tb_inst_encode_writer
// Directed scenarios followed by randomized traffic, checked against an
// arithmetic reference model (legal immediate ranges, shifted field placement,
// a queue of expected words) that tracks every clock edge.
module tb_inst_encode_writer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        err_clear;
    logic        mem_wr_en;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [2:0]  fifo_count;
    logic        err_imm;
    logic [15:0] words_written;

    int checks = 0;
    int errors = 0;
    logic checkEn = 1'b0;
    logic randomMode = 1'b0;

    logic [31:0] expQ[$];
    logic [31:0] modelAddr;
    logic        modelErr;
    logic [15:0] modelWords;
    logic        mAccept, mLegal;

    inst_encode_writer #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
        .err_clear(err_clear), .mem_wr_en(mem_wr_en), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .fifo_count(fifo_count),
        .err_imm(err_imm), .words_written(words_written)
    );

    always #5 clk = ~clk;

    // Global watchdog so the run can never hang
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference legality: immediate must lie in the representable signed range / alignment
    function automatic logic refLegal(input logic [31:0] op, input logic [31:0] f3, input logic [31:0] imm);
        longint s;
        s = longint'($signed(imm));
        case (op)
            32'h13, 32'h03, 32'h67: begin
`ifdef INST_ENC_SHAMT_CHECK_EN
                if (op == 32'h13 && (f3 == 1 || f3 == 5))
                    return (imm < 32) || (f3 == 5 && imm >= 32'h400 && imm < 32'h420);
`endif
                return (s >= -2048 && s <= 2047);
            end
            32'h23:         return (s >= -2048 && s <= 2047);
            32'h63:         return (s >= -4096 && s <= 4095 && (s % 2 == 0));
            32'h37, 32'h17: return (imm % 4096 == 0);
            32'h6F:         return (s >= -1048576 && s <= 1048575 && (s % 2 == 0));
            32'h33:         return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    // Reference encoding built from shifts and masks of the arguments
    function automatic logic [31:0] refEncode(input logic [31:0] op, input logic [31:0] rd,
                                              input logic [31:0] rs1, input logic [31:0] rs2,
                                              input logic [31:0] f3, input logic [31:0] f7,
                                              input logic [31:0] imm);
        case (op)
            32'h13, 32'h03, 32'h67:
                return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
            32'h23:
                return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) |
                       ((imm & 32'h1F) << 7) | op;
            32'h63:
                return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) |
                       (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8) |
                       (((imm >> 11) & 1) << 7) | op;
            32'h37, 32'h17:
                return (imm & 32'hFFFFF000) | (rd << 7) | op;
            32'h6F:
                return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                       (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | op;
            default:
                return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
        endcase
    endfunction

    // Branch immediate decoder, as the core's immediate generator would see it
    function automatic logic [31:0] decodeBImm(input logic [31:0] w);
        logic [31:0] v;
        v = (((w >> 7) & 1) << 11) | (((w >> 25) & 32'h3F) << 5) | (((w >> 8) & 32'hF) << 1);
        if (w[31]) v = v | 32'hFFFFF000;
        return v;
    endfunction

    // Per-cycle model: check outputs at the falling edge, then predict the next rising edge
    always @(negedge clk) begin
        if (!reset) begin
            expQ.delete();
            modelAddr  = 32'h0;
            modelErr   = 1'b0;
            modelWords = 16'd0;
        end else if (checkEn) begin
            checkOutput("fifo_count", 32'(fifo_count), 32'(expQ.size()));
            checkOutput("in_ready", 32'(in_ready), 32'(expQ.size() < DEPTH));
            checkOutput("mem_wr_en", 32'(mem_wr_en), 32'(expQ.size() != 0));
            checkOutput("mem_addr", mem_addr, modelAddr);
            checkOutput("err_imm", 32'(err_imm), 32'(modelErr));
            checkOutput("words_written", 32'(words_written), 32'(modelWords));
            if (expQ.size() != 0) checkOutput("mem_wr_data", mem_wr_data, expQ[0]);
            mAccept = in_valid && (expQ.size() < DEPTH);
            mLegal  = refLegal(32'(in_opcode), 32'(in_funct3), in_imm);
            if (expQ.size() != 0 && mem_ready) begin
                void'(expQ.pop_front());
                modelAddr  = modelAddr + 32'd4;
                modelWords = modelWords + 16'd1;
            end
            if (mAccept && mLegal)
                expQ.push_back(refEncode(32'(in_opcode), 32'(in_rd), 32'(in_rs1), 32'(in_rs2),
                                         32'(in_funct3), 32'(in_funct7), in_imm));
            if (mAccept && !mLegal) modelErr = 1'b1;
            else if (err_clear)     modelErr = 1'b0;
        end
    end

    task automatic randomizeSide();
        if (randomMode) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            err_clear = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm);
        logic acc;
        acc       = 1'b0;
        in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
        in_valid  = 1'b1;
        for (int c = 0; c < 40 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            randomizeSide();
        end
        in_valid = 1'b0;
        if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            randomizeSide();
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic drain();
        logic done;
        done      = 1'b0;
        mem_ready = 1'b1;
        for (int c = 0; c < 100 && !done; c++) begin
            @(posedge clk);
            #1;
            done = (expQ.size() == 0);
        end
        if (!done) checkOutput("drain_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [6:0]  ops [10];
        logic [6:0]  op;
        logic [31:0] imm;
        logic [31:0] edges [12];
        ops   = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};
        edges = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4095, -32'sd4096,
                  32'hFFFFF000, 32'h00100000, 32'h000FFFFE, 32'hFFF00000, 32'd7};
        reset = 1'b0; in_valid = 1'b0; mem_ready = 1'b0; err_clear = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkEn = 1'b1;
        @(negedge clk);
        checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_wr_en", 32'(mem_wr_en), 32'd0);
        checkOutput("rst_addr", mem_addr, 32'h0);
        checkOutput("rst_err", 32'(err_imm), 32'd0);
        checkOutput("rst_words", 32'(words_written), 32'd0);
        checkOutput("rst_data", mem_wr_data, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // addi x1,x0,5 with memory always ready
        mem_ready = 1'b1;
        applyStimulus(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(negedge clk);
        checkOutput("addi_en", 32'(mem_wr_en), 32'd1);
        checkOutput("addi_data", mem_wr_data, 32'h00500093);
        checkOutput("addi_addr", mem_addr, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("addi_words", 32'(words_written), 32'd1);
        checkOutput("addi_addr_next", mem_addr, 32'h4);

        // sw x2,-4(x1) then lui x5,0x12345
        doReset();
        mem_ready = 1'b0;
        applyStimulus(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFFFFFC);
        applyStimulus(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000);
        @(negedge clk);
        checkOutput("sw_data", mem_wr_data, 32'hFE20AE23);
        checkOutput("sw_count", 32'(fifo_count), 32'd2);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("lui_data", mem_wr_data, 32'h123452B7);
        checkOutput("lui_addr", mem_addr, 32'h4);
        drain();
        checkOutput("sw_lui_words", 32'(words_written), 32'd2);

        // beq x0,x0,+8 and round trip through the immediate decoder
        doReset();
        mem_ready = 1'b0;
        applyStimulus(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        @(negedge clk);
        checkOutput("beq_data", mem_wr_data, 32'h00000463);
        checkOutput("beq_decode", decodeBImm(mem_wr_data), 32'd8);
        drain();

        // Illegal jal immediates: accepted, dropped, sticky error, clear
        doReset();
        mem_ready = 1'b1;
        applyStimulus(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        applyStimulus(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100000);
        @(negedge clk);
        checkOutput("jal_err", 32'(err_imm), 32'd1);
        checkOutput("jal_addr", mem_addr, 32'h0);
        checkOutput("jal_count", 32'(fifo_count), 32'd0);
        err_clear = 1'b1;
        @(posedge clk); #1;
        err_clear = 1'b0;
        @(negedge clk);
        checkOutput("err_cleared", 32'(err_imm), 32'd0);
        // Rejection on the same edge as err_clear keeps the flag set
        err_clear = 1'b1;
        applyStimulus(7'h37, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000123);
        err_clear = 1'b0;
        @(negedge clk);
        checkOutput("err_wins", 32'(err_imm), 32'd1);

        // Back-pressure: fill the FIFO, then release memory
        doReset();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            applyStimulus(7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i * 16));
        @(negedge clk);
        checkOutput("full_ready", 32'(in_ready), 32'd0);
        checkOutput("full_count", 32'(fifo_count), 32'd4);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        applyStimulus(7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 7'h20, 32'hDEADBEEF);
        drain();
        checkOutput("full_words", 32'(words_written), 32'd5);
        checkOutput("full_addr", mem_addr, 32'h14);

        // Reset with words queued and error pending
        doReset();
        mem_ready = 1'b0;
        applyStimulus(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        applyStimulus(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        applyStimulus(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
        doReset();
        @(negedge clk);
        checkOutput("mid_rst_count", 32'(fifo_count), 32'd0);
        checkOutput("mid_rst_en", 32'(mem_wr_en), 32'd0);
        checkOutput("mid_rst_addr", mem_addr, 32'h0);
        checkOutput("mid_rst_err", 32'(err_imm), 32'd0);
        @(posedge clk); #1;
        mem_ready = 1'b1;
        idleCycles(5);
        @(negedge clk);
        checkOutput("mid_rst_nowrite", 32'(words_written), 32'd0);

        // Randomized traffic
        randomMode = 1'b1;
        for (int n = 0; n < 200; n++) begin
            op = ops[$urandom_range(0, 9)];
            case ($urandom_range(0, 5))
                0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1: imm = edges[$urandom_range(0, 11)];
                2: imm = $urandom;
                3: imm = $urandom & 32'hFFFFF000;
                4: imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFFFFFE;
                default: imm = 32'($urandom_range(0, 63));
            endcase
            applyStimulus(op, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom),
                          7'($urandom), imm);
            idleCycles($urandom_range(0, 2));
        end
        randomMode = 1'b0;
        err_clear  = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_encode_writer.md
Name: inst_encode_writer

Overview:
- Inverse of the immediate generator: packs instruction fields plus a full 32-bit immediate into a RV32I instruction word.
- Words are buffered in a small FIFO and streamed to an instruction-memory write port at consecutive word addresses.
- Used by the loader/self-test path to build programs in instruction memory.
- Immediate range/alignment is checked, so a word it writes always decodes back to the original `in_imm`.

Parameters:
- FIFO_DEPTH, 4, output FIFO entries (power of 2, ≥2)
- ADDR_WIDTH, 32, memory address width
- BASE_ADDR, 0, first write address after reset (word-aligned)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-low reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept
- in_opcode  input  7  instruction opcode
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R-type only)
- in_imm  input  32  full-width immediate value as consumed by the decoder
- err_clear  input  1  clears err_imm
- mem_wr_en  output  1  write request
- mem_ready  input  1  memory accepts write this cycle
- mem_addr  output  ADDR_WIDTH  write address
- mem_wr_data  output  32  encoded instruction
- fifo_count  output  $clog2(FIFO_DEPTH)+1  occupancy
- err_imm  output  1  sticky: a bundle was rejected
- words_written  output  16  count of completed writes, wraps

Behaviour:
- Reset (reset==0 at clk edge):
  - FIFO emptied; fifo_count=0, mem_wr_en=0.
  - mem_addr=BASE_ADDR, err_imm=0, words_written=0, mem_wr_data=0.
  - Any in-flight word is discarded; reset overrides all simultaneous events.
- Input handshake:
  - in_ready = (fifo_count < FIFO_DEPTH); it depends only on registered count, with no full-bypass.
  - A bundle is accepted on an edge where in_valid && in_ready.
  - Encoding is combinational. A legal word is pushed at the accept edge.
- Format by opcode:
  - I-type: 0010011, 0000011, 1100111
  - S-type: 0100011
  - B-type: 1100011
  - U-type: 0110111, 0010111
  - J-type: 1101111
  - R-type: 0110011; in_imm is ignored
- Field packing: standard RV32I bit placement; unused fields are zero (e.g. U/J contain no rs/funct3).
- Legality checks:
  - I/S: in_imm[31:11] all equal.
  - B: in_imm[0]==0 and in_imm[31:12] all equal.
  - J: in_imm[0]==0 and in_imm[31:20] all equal.
  - U: in_imm[11:0]==0.
  - Any other opcode is illegal.
- Illegal bundle:
  - Still accepted (handshake completes) but not pushed.
  - err_imm=1 from the next cycle; address is unchanged.
- err_imm: cleared by err_clear; a rejection on the same edge as err_clear wins (stays 1).
- Writer FSM (registered):
  - W_IDLE (FIFO empty, mem_wr_en=0) → W_WRITE when count becomes nonzero.
  - W_WRITE: mem_wr_en=1, mem_wr_data=FIFO head, held stable until mem_ready.
  - On an edge with mem_ready: pop head, mem_addr += 4 (wraps mod 2^ADDR_WIDTH), words_written += 1.
  - Stay in W_WRITE if entries remain, else go to W_IDLE.
- Latency: accept at edge N → mem_wr_en high in cycle N+1 at the earliest.
- Ordering: writes occur strictly in acceptance order.
- Simultaneous push and pop: count unchanged, both take effect. When full, no push occurs that cycle even if a pop happens.

Optional Feature:
- Macro: INST_ENC_SHAMT_CHECK_EN.
- Defined: for opcode 0010011 with funct3 001 or 101, in_imm[4:0] is free, in_imm[11:5] must be 0000000 (or 0100000 only when funct3=101), and in_imm[31:12] must be 0. Anything else is illegal (dropped, err_imm set).
- Undefined: these are treated as generic I-type and only the 12-bit signed check applies.

Test Plan:
- addi x1,x0,5 (0010011, rd=1, f3=0, imm=5), mem_ready=1 → single write 0x00500093 at addr 0x0, words_written=1.
- sw x2,-4(x1) (imm=0xFFFFFFFC) then lui x5 (imm=0x12345000) → writes 0xFE20AE23 @0x0, 0x123452B7 @0x4.
- beq x0,x0,+8 (1100011, imm=8) → 0x00000463; feeding that word to the immediate decoder returns 0x00000008.
- jal x1 with imm=3, then imm=0x00100000 → both accepted, neither written, err_imm=1, mem_addr stays 0x0; err_clear pulse → err_imm=0.
- mem_ready=0, push 5 legal bundles → in_ready=0 after 4th, fifo_count=4; release mem_ready → 4 writes at 0x0,0x4,0x8,0xC in order, 5th accepted once space frees.
- 2 words queued, reset=0 one cycle → next cycle fifo_count=0, mem_wr_en=0, mem_addr=BASE_ADDR, err_imm=0, nothing written after.
